// File: rtl/led_shift_driver.sv
// Shifts a WIDTH-bit frame MSB first into an external SIPO shift-register chain,
// then pulses the storage latch. Everything runs on clk; sclk is a divided, registered output.
`timescale 1ns/1ps

module led_shift_driver #(
  parameter int WIDTH      = 64,
  parameter int CLK_DIV    = 10,
  parameter int LOAD_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             sclk,
  output logic             sdat,
  output logic             latch,
  output logic             busy,
  output logic             done
);

  // Counter widths are floored at one bit so a parameter value of 1 still elaborates.
  localparam int DIV_W = (CLK_DIV    > 1) ? $clog2(CLK_DIV)    : 1;
  localparam int BIT_W = (WIDTH      > 1) ? $clog2(WIDTH)      : 1;
  localparam int DLY_W = (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(LOAD_DELAY - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_LATCH
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q,   div_d;
  logic [DLY_W-1:0]   dly_q,   dly_d;
  logic [BIT_W-1:0]   bit_q,   bit_d;
  logic [WIDTH-1:0]   sreg_q,  sreg_d;
  logic               pend_q,  pend_d;
  logic               sclk_d, sdat_d, latch_d, busy_d, done_d;

  // NOTE: every register is updated with <= so all of them see the same pre-edge
  // values; blocking assignments here would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      dly_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      pend_q  <= 1'b0;
      sclk    <= 1'b0;
      sdat    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      pend_q  <= pend_d;
      sclk    <= sclk_d;
      sdat    <= sdat_d;
      latch   <= latch_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  always_comb begin
    // NOTE: every target gets a hold-value default first, so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d = state_q;
    div_d   = div_q;
    dly_d   = dly_q;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    pend_d  = pend_q;
    sclk_d  = sclk;
    sdat_d  = sdat;
    latch_d = latch;
    busy_d  = busy;
    done_d  = 1'b0;

    // One-deep queue: a load arriving mid-frame is remembered, later ones are lost.
    if (state_q != S_IDLE && load) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (load || pend_q) begin
          state_d = S_WAIT;
          busy_d  = 1'b1;
          dly_d   = '0;
          pend_d  = 1'b0;
        end
      end

      S_WAIT: begin
        if (dly_q == DLY_LAST) begin
          sreg_d  = din;
          sdat_d  = din[WIDTH-1];
          bit_d   = BIT_TOP;
          sclk_d  = 1'b0;
          state_d = S_SHIFT_LO;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      S_SHIFT_LO: begin
        if (div_q == DIV_LAST) begin
          sclk_d  = 1'b1;
          state_d = S_SHIFT_HI;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_SHIFT_HI: begin
        if (div_q == DIV_LAST) begin
          sclk_d = 1'b0;
          if (bit_q != '0) begin
            // Next bit is presented on the falling edge, a full half period before its rise.
            sreg_d  = sreg_q << 1;
            sdat_d  = sreg_d[WIDTH-1];
            bit_d   = bit_q - 1'b1;
            state_d = S_SHIFT_LO;
          end else begin
            sdat_d  = 1'b0;
            latch_d = 1'b1;
            state_d = S_LATCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_LATCH: begin
        if (div_q == DIV_LAST) begin
          latch_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The divider restarts on every state change so each phase lasts exactly CLK_DIV clocks.
    if (state_d != state_q) begin
      div_d = '0;
    end
  end

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: a 64-bit default instance driven from a
// vector table plus back-to-back and mid-frame reset sequences, and an 8-bit CLK_DIV=1 instance.
`timescale 1ns/1ps

module tb_led_shift_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a, load_b;
  logic [63:0] din_a;
  logic [7:0]  din_b;
  logic        sclk_a, sdat_a, latch_a, busy_a, done_a;
  logic        sclk_b, sdat_b, latch_b, busy_b, done_b;

  always #5 clk = ~clk;

  led_shift_driver #(.WIDTH(64), .CLK_DIV(10), .LOAD_DELAY(1)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .din(din_a),
    .sclk(sclk_a), .sdat(sdat_a), .latch(latch_a), .busy(busy_a), .done(done_a)
  );

  led_shift_driver #(.WIDTH(8), .CLK_DIV(1), .LOAD_DELAY(1)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .din(din_b),
    .sclk(sclk_b), .sdat(sdat_b), .latch(latch_b), .busy(busy_b), .done(done_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] pre;        // din during the load clock (must not be captured)
    logic [63:0] data;       // din one clock later (must be shifted out)
    int          exp_rises;
    int          exp_latch;
    int          exp_done;   // clocks from load acceptance to done
  } vec_t;

  vec_t vecs [5];

  // Results of the most recent run_a call.
  logic [127:0] bits;
  int rises, latch_cyc, done_cnt, done_at1, done_at2, busy_low, sdat_bad, busy_acc;

  // Starts a frame on dut_a at a negedge and observes it until n_frames done pulses.
  task automatic run_a(input logic [63:0] pre, input logic [63:0] data, input logic [63:0] data2,
                       input int extra1, input int extra2, input int n_frames, input int budget);
    logic prev_sclk, prev_sdat;
    bits = '0; rises = 0; latch_cyc = 0; done_cnt = 0;
    done_at1 = -1; done_at2 = -1; busy_low = 0; sdat_bad = 0;
    load_a = 1'b1;
    din_a  = pre;
    @(negedge clk);
    busy_acc = int'(busy_a);
    load_a = 1'b0;
    din_a  = data;
    prev_sclk = sclk_a;
    prev_sdat = sdat_a;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 2) din_a = data2;
      load_a = (n == extra1 || n == extra2);
      if (sclk_a && !prev_sclk) begin
        bits = {bits[126:0], sdat_a};
        rises++;
      end
      if (sdat_a != prev_sdat && sclk_a) sdat_bad++;
      if (latch_a) latch_cyc++;
      if (!busy_a) busy_low++;
      if (done_a) begin
        done_cnt++;
        if (done_cnt == 1) done_at1 = n;
        else done_at2 = n;
      end
      prev_sclk = sclk_a;
      prev_sdat = sdat_a;
      if (done_cnt == n_frames) break;
    end
    load_a = 1'b0;
  endtask

  initial begin
    int any_out, cnt_latch, cnt_done, cnt_rise;
    logic prev;
    logic [7:0] bits_b;
    int rises_b, latch_b_cyc, done_b_at, tog_bad;

    vecs[0] = '{64'h0,                   64'hA5A5_0000_FFFF_1234, 64, 10, 1291};
    vecs[1] = '{64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 64, 10, 1291};
    vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   64, 10, 1291};
    vecs[3] = '{64'h0,                   64'h8000_0000_0000_0001, 64, 10, 1291};
    vecs[4] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_3C3C_C3C3, 64, 10, 1291};

    // Reset: outputs must be low before any clock edge.
    rst = 1'b1; load_a = 1'b0; load_b = 1'b0; din_a = '0; din_b = '0;
    #1;
    check("reset_outputs_a", {59'd0, sclk_a, sdat_a, latch_a, busy_a, done_a}, 64'd0);
    check("reset_outputs_b", {59'd0, sclk_b, sdat_b, latch_b, busy_b, done_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    any_out = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk_a | sdat_a | latch_a | busy_a | done_a | sclk_b | sdat_b | latch_b | busy_b | done_b)
        any_out++;
    end
    check("idle_outputs_stay_low", any_out, 0);

    // Table-driven single frames; each row also checks that din is sampled one clock after load.
    foreach (vecs[i]) begin
      run_a(vecs[i].pre, vecs[i].data, ~vecs[i].data, 0, 0, 1, 3000);
      check($sformatf("v%0d_busy_on_accept", i), busy_acc, 1);
      check($sformatf("v%0d_sclk_rises", i), rises, vecs[i].exp_rises);
      check($sformatf("v%0d_frame", i), bits[63:0], vecs[i].data);
      check($sformatf("v%0d_latch_clocks", i), latch_cyc, vecs[i].exp_latch);
      check($sformatf("v%0d_done_latency", i), done_at1, vecs[i].exp_done);
      check($sformatf("v%0d_sdat_while_high", i), sdat_bad, 0);
      check($sformatf("v%0d_busy_low_clocks", i), busy_low, 1);
      repeat (3) @(negedge clk);
    end

    // Back-to-back: load at 200 is queued, load at 300 is dropped.
    run_a(64'h0, 64'hDEAD_BEEF_0F0F_1111, 64'h0123_4567_89AB_CDEF, 200, 300, 2, 3000);
    check("b2b_first_done", done_at1, 1291);
    check("b2b_second_done", done_at2, 2583);
    check("b2b_sclk_rises", rises, 128);
    check("b2b_frame1", bits[127:64], 64'hDEAD_BEEF_0F0F_1111);
    check("b2b_frame2", bits[63:0], 64'h0123_4567_89AB_CDEF);
    check("b2b_busy_low_clocks", busy_low, 2);
    cnt_done = 0; cnt_rise = 0; any_out = 0; prev = sclk_a;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (done_a) cnt_done++;
      if (busy_a) any_out++;
      if (sclk_a && !prev) cnt_rise++;
      prev = sclk_a;
    end
    check("b2b_third_dropped_done", cnt_done, 0);
    check("b2b_third_dropped_busy", any_out, 0);
    check("b2b_third_dropped_sclk", cnt_rise, 0);

    // Mid-frame asynchronous reset after 30 bits.
    load_a = 1'b1; din_a = '0;
    @(negedge clk);
    load_a = 1'b0; din_a = 64'hFFFF_0000_FFFF_0000;
    cnt_rise = 0; cnt_latch = 0; prev = sclk_a;
    for (int i = 0; i < 1000 && cnt_rise < 30; i++) begin
      @(negedge clk);
      if (sclk_a && !prev) cnt_rise++;
      if (latch_a) cnt_latch++;
      prev = sclk_a;
    end
    check("midrst_reached_30_bits", cnt_rise, 30);
    check("midrst_sclk_high_before", sclk_a, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_async_outputs", {59'd0, sclk_a, sdat_a, latch_a, busy_a, done_a}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    cnt_done = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (latch_a) cnt_latch++;
      if (done_a) cnt_done++;
    end
    check("midrst_no_latch", cnt_latch, 0);
    check("midrst_no_done", cnt_done, 0);
    run_a(64'h0, 64'h1357_9BDF_2468_ACE0, 64'h0, 0, 0, 1, 3000);
    check("after_rst_sclk_rises", rises, 64);
    check("after_rst_frame", bits[63:0], 64'h1357_9BDF_2468_ACE0);
    check("after_rst_done_latency", done_at1, 1291);

    // WIDTH=8, CLK_DIV=1 instance.
    load_b = 1'b1; din_b = 8'h00;
    @(negedge clk);
    load_b = 1'b0; din_b = 8'h81;
    bits_b = '0; rises_b = 0; latch_b_cyc = 0; done_b_at = -1; tog_bad = 0; prev = sclk_b;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 2) din_b = 8'h7E;
      if (sclk_b && !prev) begin
        bits_b = {bits_b[6:0], sdat_b};
        rises_b++;
      end
      if (n <= 16 && sclk_b !== ((n % 2) == 0)) tog_bad++;
      if (latch_b) latch_b_cyc++;
      if (done_b) begin
        done_b_at = n;
        break;
      end
      prev = sclk_b;
    end
    check("w8_sclk_rises", rises_b, 8);
    check("w8_frame", bits_b, 8'h81);
    check("w8_sclk_toggles_each_clock", tog_bad, 0);
    check("w8_latch_clocks", latch_b_cyc, 1);
    check("w8_done_latency", done_b_at, 18);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_shift_driver.md
# led_shift_driver

Serializes a 64-bit display frame into an external chain of serial-in/parallel-out shift registers and latches it onto the LED outputs. Sits directly downstream of the pattern ROM sequencer. It takes that stage's 64-bit frame word and its one-cycle new-frame strobe, and drives the board's shift-register pins: serial clock, serial data and storage latch. Runs entirely in the system clock domain; the serial clock is a divided, registered output.

## Interface
- `WIDTH`, 64: bits per frame; all shifted out MSB first.
- `CLK_DIV`, 10: system clocks per serial-clock half period; must be ≥1. Serial clock = clk / (2·CLK_DIV).
- `LOAD_DELAY`, 1: clocks between accepting `load` and sampling `din`. Covers the upstream ROM's one-cycle read latency; ≥1.
- `clk`  in  1  system clock; all registers rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `load`  in  1  new-frame strobe, sampled every clock.
- `din`  in  WIDTH  frame word; valid LOAD_DELAY clocks after `load`.
- `sclk`  out  1  serial clock to the shift-register chain; data is taken on its rising edge.
- `sdat`  out  1  serial data, changes only while `sclk` is low.
- `latch`  out  1  storage-register clock; high for CLK_DIV clocks after the last bit.
- `busy`  out  1  high from acceptance of a load until the frame is latched.
- `done`  out  1  one-clock pulse when a frame has been latched.

## Operation
- All outputs are registered. Reset values: `sclk`=0, `sdat`=0, `latch`=0, `busy`=0, `done`=0.
- Reset also clears the state (to IDLE), the shift register, the bit counter, the divider counter and the pending flag.
- States: IDLE → WAIT → SHIFT_LO ↔ SHIFT_HI → LATCH → IDLE.
- **IDLE**
  - `load`=1 → WAIT, `busy`=1, delay counter cleared.
- **WAIT**
  - Counts LOAD_DELAY clocks.
  - On the last one: capture `din` into the shift register, drive `sdat`=din[WIDTH-1], set bit counter = WIDTH-1, go to SHIFT_LO.
- **SHIFT_LO**
  - `sclk`=0 for CLK_DIV clocks, then → SHIFT_HI with `sclk`=1.
- **SHIFT_HI**
  - `sclk`=1 for CLK_DIV clocks.
  - If bit counter ≠ 0: shift left, present next bit on `sdat`, decrement counter, → SHIFT_LO with `sclk`=0.
  - If bit counter = 0: `sclk`=0, `sdat`=0, → LATCH with `latch`=1.
- **LATCH**
  - `latch`=1 for CLK_DIV clocks, then `latch`=0, `busy`=0, `done`=1 for one clock, → IDLE.
- **Load while busy:** `load` asserted in any non-IDLE state sets a one-deep pending flag. Further loads while it is set are dropped.
- **Pending frame:** on the IDLE-entry clock (the `done` clock), a set pending flag clears and the block goes straight to WAIT. `busy` is low only for that one clock. `din` is sampled fresh LOAD_DELAY clocks later.
- **Load on the `done` clock:** treated as a normal IDLE acceptance.
- **Divider:** one counter, width $clog2(CLK_DIV), reset to 0 on every state change.
- **Bit counter:** width $clog2(WIDTH).
- **Async reset mid-frame:** all outputs drop to reset values immediately. The external latch is not pulsed, so partial data is never displayed.

## Timing
- Load accepted at edge t. Then:
  - `busy`=1 from t.
  - `din` captured at edge t+LOAD_DELAY.
  - First `sclk` rise at t+LOAD_DELAY+CLK_DIV.
- Bit k (0 = MSB) rises at t+LOAD_DELAY+(2k+1)·CLK_DIV.
- `latch` high over clocks [t+LOAD_DELAY+2·WIDTH·CLK_DIV, +CLK_DIV).
- `done` and `busy` falling at t+LOAD_DELAY+(2·WIDTH+1)·CLK_DIV.
- With defaults, `busy` lasts 1291 clocks, 6.455 µs at 200 MHz. This is far below the 100 ms upstream frame period.
- `sdat` is stable at least CLK_DIV clocks before and after each `sclk` rise.

## Test plan
- **Reset:** assert `rst` asynchronously → all outputs 0 with no clock edge needed. Release, hold `load`=0 for 100 clocks → outputs stay 0.
- **Single frame:** defaults, `din`=64'hA5A5_0000_FFFF_1234 one clock after a `load` pulse. Required:
  - Exactly 64 `sclk` rises.
  - The bench reassembles the captured bits to 64'hA5A5_0000_FFFF_1234.
  - `latch` is high 10 clocks; `done` pulses 1291 clocks after load.
- **Latency:** LOAD_DELAY=1. `din` changes from 0 to all-ones exactly one clock after `load` → all-ones is shifted, not 0.
- **Back-to-back:** second `load` 200 clocks into a frame, third at 300 → exactly two frames sent. `busy` is low for exactly one clock between them; the third load is dropped.
- **Mid-frame reset:** `rst` pulse after 30 bits → `latch` never pulses. A following load sends a complete 64-bit frame.
- **Parameters:** CLK_DIV=1, WIDTH=8, `din`=8'h81 → `sclk` toggles every clock, bits 1,0,0,0,0,0,0,1, `done` at 1+17 clocks.
